// File: rtl/y86_pipe_monitor.sv
// Run monitor for the Y86-64 pipeline: run-state tracking, saturating
// performance counters, per-icode retire histogram, no-progress watchdog
// and a registered select-indexed readout port.
module y86_pipe_monitor #(
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned TIMEOUT   = 1024,
    parameter int unsigned NUM_ICODE = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic [3:0]       W_icode,
    input  logic [1:0]       W_stat,
    input  logic [3:0]       M_icode,
    input  logic             M_Cnd,
    input  logic             F_stall,
    input  logic [4:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic [2:0]       state,
    output logic             done,
    output logic [1:0]       err_stat
);

    localparam int unsigned     WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_HALTED  = 3'd2,
        ST_ERROR   = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    state_t           state_q;
    logic [WD_W-1:0]  wd_q;
    logic [CNT_W-1:0] cycles_q;
    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] bubbles_q;
    logic [CNT_W-1:0] stalls_q;
    logic [CNT_W-1:0] mispred_q;
    logic [CNT_W-1:0] hist_q [NUM_ICODE];

    logic                 in_run;
    logic                 ev_retire;
    logic                 ev_bubble;
    logic                 ev_halt;
    logic                 ev_err;
    logic                 ev_mispred;
    logic                 wd_expire;
    logic [NUM_ICODE-1:0] hist_hit;
    logic [CNT_W-1:0]     rd_mux;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Decode this cycle's pipeline events; halt retires and always bins into icode 0
    always_comb begin
        in_run     = (state_q == ST_RUN);
        ev_retire  = (W_stat == 2'b00) && (W_icode != 4'd1);
        ev_bubble  = (W_stat == 2'b00) && (W_icode == 4'd1);
        ev_halt    = (W_stat == 2'b01);
        ev_err     = W_stat[1];
        ev_mispred = (M_icode == 4'd7) && !M_Cnd;
        wd_expire  = (wd_q == WD_W'(TIMEOUT - 1));
        for (int i = 0; i < NUM_ICODE; i++) begin
            hist_hit[i] = (ev_retire && (W_icode == 4'(i))) || (ev_halt && (i == 0));
        end
    end

    // Run-state machine, watchdog and error-status capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wd_q     <= '0;
            err_stat <= 2'b00;
        end else if (clear) begin
            state_q  <= ST_IDLE;
            wd_q     <= '0;
            err_stat <= 2'b00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_RUN;
                        wd_q    <= '0;
                    end
                end
                ST_RUN: begin
                    if (ev_retire || ev_halt) begin
                        wd_q <= '0;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                    if (ev_halt) begin
                        state_q <= ST_HALTED;
                    end else if (ev_err) begin
                        state_q  <= ST_ERROR;
                        err_stat <= W_stat;
                    end else if (!ev_retire && wd_expire) begin
                        state_q <= ST_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    // Saturating performance counters, live only while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles_q  <= '0;
            retired_q <= '0;
            bubbles_q <= '0;
            stalls_q  <= '0;
            mispred_q <= '0;
            for (int i = 0; i < NUM_ICODE; i++) begin
                hist_q[i] <= '0;
            end
        end else if (clear) begin
            cycles_q  <= '0;
            retired_q <= '0;
            bubbles_q <= '0;
            stalls_q  <= '0;
            mispred_q <= '0;
            for (int i = 0; i < NUM_ICODE; i++) begin
                hist_q[i] <= '0;
            end
        end else if (in_run) begin
            cycles_q <= sat_inc(cycles_q);
            if (ev_retire || ev_halt) begin
                retired_q <= sat_inc(retired_q);
            end
            if (ev_bubble) begin
                bubbles_q <= sat_inc(bubbles_q);
            end
            if (F_stall) begin
                stalls_q <= sat_inc(stalls_q);
            end
            if (ev_mispred) begin
                mispred_q <= sat_inc(mispred_q);
            end
            for (int i = 0; i < NUM_ICODE; i++) begin
                if (hist_hit[i]) begin
                    hist_q[i] <= sat_inc(hist_q[i]);
                end
            end
        end
    end

    // Readout select mux; unmapped selects read zero
    always_comb begin
        rd_mux = '0;
        case (rd_sel)
            5'd0: rd_mux = cycles_q;
            5'd1: rd_mux = retired_q;
            5'd2: rd_mux = bubbles_q;
            5'd3: rd_mux = stalls_q;
            5'd4: rd_mux = mispred_q;
            5'd5: rd_mux = CNT_W'(wd_q);
            default: begin
                for (int i = 0; i < NUM_ICODE; i++) begin
                    if (rd_sel == 5'(8 + i)) begin
                        rd_mux = hist_q[i];
                    end
                end
            end
        endcase
    end

    // Registered readout port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_mux;
        end
    end

    assign state = state_q;
    assign done  = (state_q == ST_HALTED) || (state_q == ST_ERROR) || (state_q == ST_TIMEOUT);

endmodule

// File: doc/y86_pipe_monitor.md
# y86_pipe_monitor

Synthesizable run monitor for the Y86-64 pipelined core: observes writeback, memory and fetch-stage control signals, and tracks run state (idle/run/halted/error/timeout). It keeps saturating performance counters (cycles, retired instructions, bubbles, fetch stalls, mispredicted jumps) and a per-icode retire histogram. A no-progress watchdog flags hung pipelines. It sits beside the pipeline wrapper, and benches read it through a select-indexed readout port instead of scraping waveforms.

## Interface
- CNT_W, 32, width of every counter (min 8)
- TIMEOUT, 1024, cycles without a non-nop retire before TIMEOUT state (≥2)
- NUM_ICODE, 12, histogram channels (icodes 0..NUM_ICODE-1; larger icodes are not binned)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; IDLE→RUN
- clear  in  1  pulse; zero all counters, any state→IDLE
- W_icode  in  4  writeback-stage icode
- W_stat  in  2  writeback status: 00 AOK, 01 HLT, 10 ADR, 11 INS
- M_icode  in  4  memory-stage icode
- M_Cnd  in  1  memory-stage branch condition
- F_stall  in  1  fetch stall this cycle
- rd_sel  in  5  readout select
- rd_data  out  CNT_W  selected counter, registered
- state  out  3  0 IDLE, 1 RUN, 2 HALTED, 3 ERROR, 4 TIMEOUT
- done  out  1  state ∈ {HALTED, ERROR, TIMEOUT}
- err_stat  out  2  W_stat captured on entry to ERROR, else 00

## Operation
- Reset: state=IDLE, all counters 0, watchdog 0, rd_data=0, done=0, err_stat=00.
- Counters update only in RUN, on the cycle the event is sampled:
  - cycles: +1 every RUN cycle
  - retired: +1 when W_stat==AOK and W_icode≠1 (nop/bubble)
  - bubbles: +1 when W_stat==AOK and W_icode==1
  - stalls: +1 when F_stall
  - mispredicts: +1 when M_icode==7 (jXX) and M_Cnd==0
  - hist[i]: +1 when the retired condition holds and W_icode==i, i<NUM_ICODE
- All counters saturate at 2^CNT_W−1 and never wrap.
- Transitions, priority top-down:
  - clear: any state→IDLE, counters and watchdog zeroed. Clear outranks start and all RUN exits.
  - IDLE + start→RUN. start outside IDLE is ignored.
  - RUN + W_stat==HLT→HALTED. The halt instruction counts as retired and bins into hist[0].
  - RUN + W_stat∈{ADR,INS}→ERROR. err_stat latches W_stat; the instruction is not counted.
  - RUN + watchdog reaches TIMEOUT−1 with no retire this cycle→TIMEOUT.
  - Terminal states hold until clear.
- Watchdog:
  - Resets to 0 on any retire and on entry to RUN.
  - Otherwise increments each RUN cycle.
  - Frozen outside RUN.
- Readout, registered (rd_data valid the cycle after rd_sel):
  - 0 cycles, 1 retired, 2 bubbles, 3 stalls, 4 mispredicts, 5 watchdog
  - 8+i hist[i]
  - all other selects read 0
- Counters stay readable in every state, including after done.

## Timing
- Single clock domain. All outputs are registered except done, which is decoded from the state register.
- Event on cycle N is visible in rd_data at end of cycle N+2 with rd_sel held: count updates at edge N→N+1, readout register at N+1→N+2.
- State changes at the edge following the triggering sample.
  - The cycle of a HLT/error sample is counted in cycles.
  - The first terminal-state cycle is not counted.
- start and clear in the same cycle: clear wins and state is IDLE.
- Asynchronous reset mid-RUN: immediate return to reset values, no partial updates.
- Simultaneous HLT status and watchdog expiry: HALTED wins.

## Test plan
- Reset then idle: rst_n low 3 cycles, release, hold start=0 for 10 cycles → state=0, all rd_sel 0..19 read 0, done=0.
- Normal run:
  - stimulus: start; 5 AOK retires of icode 3, 2 of icode 1, then W_stat=01 with W_icode=0
  - required: retired=6, bubbles=2, hist[3]=5, hist[0]=1, cycles=8, state=2, done=1
- Mispredict/stall: in RUN, 3 cycles M_icode=7/M_Cnd=0, 1 cycle M_icode=7/M_Cnd=1, 4 cycles F_stall=1 → mispredicts=3, stalls=4.
- Error: in RUN, W_stat=11 → state=3, err_stat=11, retired unchanged; then clear → state=0, err_stat=00, counters 0.
- Watchdog, TIMEOUT=16:
  - only W_icode=1 for 16 cycles → state=4 on the 17th edge
  - separately, one non-nop retire at cycle 10 → no timeout before cycle 26
- Saturation, CNT_W=8: 300 AOK retires of icode 2 → retired=255, hist[2]=255; readout of sel 31 → 0.
